// File: rtl/bcd_counter_0_99.sv
// ============================================================================
// Module   : bcd_counter_0_99
// Brief    : Two-digit BCD up/down counter stepped by a synchronised tick_in
//            edge, with a multiplexed active-low 7-segment display driver.
//            Define COUNT_SATURATE_EN to hold at 00/99 instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_counter_0_99 #(
  parameter logic [31:0] REFRESH_DIV = 32'd100000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       up_down,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry_out,
  output logic       running,
  output logic [6:0] seg,
  output logic [3:0] an
);

  typedef enum logic [0:0] {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [1:0]             rst_sync_q, rst_sync_d;
  logic                   rst_n_int;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   step_q, step_d;
  state_t                 state_q, state_d;
  logic [3:0]             ones_q, ones_d;
  logic [3:0]             tens_q, tens_d;
  logic                   carry_q, carry_d;
  logic [31:0]            refresh_q, refresh_d;
  logic                   sel_q, sel_d;
  logic [3:0]             an_q, an_d;
  logic [6:0]             seg_q, seg_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Reset asserts asynchronously but is released on a clock edge.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n_int  = rst_sync_q[1];

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], tick_in};
    prev_d  = sync_q[SYNC_STAGES-1];
    step_d  = sync_q[SYNC_STAGES-1] & ~prev_q;

    state_d = state_q;
    if (stop)       state_d = ST_STOP;
    else if (start) state_d = ST_RUN;

    ones_d  = ones_q;
    tens_d  = tens_q;
    carry_d = 1'b0;
    if (clear) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (step_q && (state_q == ST_RUN)) begin
      if (up_down) begin
`ifdef COUNT_SATURATE_EN
        if (!((ones_q == 4'd9) && (tens_q == 4'd9))) begin
`else
        begin
`endif
          if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            if (tens_q == 4'd9) begin
              tens_d  = 4'd0;
`ifndef COUNT_SATURATE_EN
              carry_d = 1'b1;
`endif
            end else begin
              tens_d = tens_q + 4'd1;
            end
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end
      end else begin
`ifdef COUNT_SATURATE_EN
        if (!((ones_q == 4'd0) && (tens_q == 4'd0))) begin
`else
        begin
`endif
          if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            if (tens_q == 4'd0) begin
              tens_d  = 4'd9;
`ifndef COUNT_SATURATE_EN
              carry_d = 1'b1;
`endif
            end else begin
              tens_d = tens_q - 4'd1;
            end
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end
      end
    end

    // >= rather than == so an overshoot still wraps back into range.
    refresh_d = refresh_q + 32'd1;
    sel_d     = sel_q;
    if (refresh_q >= (REFRESH_DIV - 32'd1)) begin
      refresh_d = 32'd0;
      sel_d     = ~sel_q;
    end
    an_d  = sel_d ? 4'b1101 : 4'b1110;
    seg_d = seg_decode(sel_d ? tens_q : ones_q);
  end

  always_ff @(posedge clock_in or negedge rst_n_int) begin
    if (!rst_n_int) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      step_q    <= 1'b0;
      state_q   <= ST_STOP;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      carry_q   <= 1'b0;
      refresh_q <= 32'd0;
      sel_q     <= 1'b0;
      an_q      <= 4'b1110;
      seg_q     <= 7'b1000000;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      step_q    <= step_d;
      state_q   <= state_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      carry_q   <= carry_d;
      refresh_q <= refresh_d;
      sel_q     <= sel_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign ones      = ones_q;
  assign tens      = tens_q;
  assign carry_out = carry_q;
  assign running   = (state_q == ST_RUN);
  assign seg       = seg_q;
  assign an        = an_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter_0_99.sv
// ============================================================================
// Module   : tb_bcd_counter_0_99
// Brief    : Directed scoreboard bench for bcd_counter_0_99 (REFRESH_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_counter_0_99;

  logic       clk;
  logic       reset_n;
  logic       tick_in;
  logic       start;
  logic       stop;
  logic       clear;
  logic       up_down;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       carry_out;
  logic       running;
  logic [6:0] seg;
  logic [3:0] an;

  int         total = 0;
  int         bad   = 0;
  int         m_val = 0;
  logic       m_run = 1'b0;
  logic [8:0] sb[$];

  bcd_counter_0_99 #(
    .REFRESH_DIV(32'd4),
    .SYNC_STAGES(2)
  ) dut (
    .clock_in (clk),
    .reset_n  (reset_n),
    .tick_in  (tick_in),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .up_down  (up_down),
    .ones     (ones),
    .tens     (tens),
    .carry_out(carry_out),
    .running  (running),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_step(output logic c);
    c = 1'b0;
    if (m_run) begin
`ifdef COUNT_SATURATE_EN
      if (up_down) begin
        if (m_val < 99) m_val++;
      end else if (m_val > 0) begin
        m_val--;
      end
`else
      if (up_down) begin
        m_val = (m_val + 1) % 100;
        c     = (m_val == 0);
      end else begin
        m_val = (m_val + 99) % 100;
        c     = (m_val == 99);
      end
`endif
    end
  endtask

  // One tick_in rising edge, high for 5 cycles then low for 5.
  task automatic do_tick(input string tag);
    logic [7:0] pre;
    logic       c;
    logic [8:0] e;
    pre = bcd(m_val);
    model_step(c);
    sb.push_back({c, bcd(m_val)});
    tick_in = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, "_pre"}, {7'b0, carry_out, tens, ones}, {7'b0, 1'b0, pre});
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, "_land"}, {7'b0, carry_out, tens, ones}, {7'b0, e});
    @(negedge clk);
    chk({tag, "_post"}, {7'b0, carry_out, tens, ones}, {7'b0, 1'b0, e[7:0]});
    tick_in = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic p, input logic c);
    start = s;
    stop  = p;
    clear = c;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    if (c) m_val = 0;
    if (p)      m_run = 1'b0;
    else if (s) m_run = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cnt"}, {7'b0, carry_out, tens, ones}, 16'h0000);
    chk({tag, "_run"}, {15'b0, running}, 16'h0000);
    chk({tag, "_an"},  {12'b0, an}, {12'b0, 4'b1110});
    chk({tag, "_seg"}, {9'b0, seg}, {9'b0, 7'b1000000});
  endtask

  initial begin
    logic [3:0] a0;
    logic [3:0] ea;
    reset_n = 1'b1;
    tick_in = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    clear   = 1'b0;
    up_down = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Count to 47 then assert reset between edges.
    pulse(1'b1, 1'b0, 1'b0);
    chk("run_after_start", {15'b0, running}, {15'b0, m_run});
    for (int i = 0; i < 47; i++) do_tick("pre47");
    #2 reset_n = 1'b0;
    #1 chk_reset("async_rst");
    m_val = 0;
    m_run = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst_release");

    // Twelve up steps.
    pulse(1'b1, 1'b0, 1'b0);
    up_down = 1'b1;
    for (int i = 0; i < 12; i++) do_tick("up12");
    chk("count12", {8'b0, tens, ones}, {8'b0, bcd(12)});

    // Preload to 98, then cross the top.
    for (int i = 0; i < 86; i++) do_tick("preload");
    do_tick("to99");
    do_tick("wrap_up");

    // Down wrap from 00 and a tens borrow.
    pulse(1'b0, 1'b0, 1'b1);
    chk("clear_00", {7'b0, carry_out, tens, ones}, 16'h0000);
    up_down = 1'b0;
    do_tick("wrap_dn");
    pulse(1'b0, 1'b0, 1'b1);
    up_down = 1'b1;
    for (int i = 0; i < 10; i++) do_tick("to10");
    up_down = 1'b0;
    do_tick("borrow");
    chk("count09", {8'b0, tens, ones}, {8'b0, bcd(9)});

    // Stopped counter ignores steps; stop beats start.
    pulse(1'b0, 1'b0, 1'b1);
    up_down = 1'b1;
    for (int i = 0; i < 5; i++) do_tick("to05");
    pulse(1'b0, 1'b1, 1'b0);
    chk("run_after_stop", {15'b0, running}, 16'h0000);
    for (int i = 0; i < 3; i++) do_tick("stopped");
    chk("hold05", {8'b0, tens, ones}, {8'b0, bcd(5)});
    pulse(1'b1, 1'b0, 1'b0);
    chk("run_restart", {15'b0, running}, 16'h0001);
    pulse(1'b1, 1'b1, 1'b0);
    chk("stop_wins", {15'b0, running}, 16'h0000);

    // Clear landing on the same cycle as a down-wrap step.
    pulse(1'b1, 1'b0, 1'b1);
    up_down = 1'b0;
    tick_in = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_vs_step", {7'b0, carry_out, tens, ones}, 16'h0000);
    @(negedge clk);
    chk("clear_vs_step2", {7'b0, carry_out, tens, ones}, 16'h0000);
    tick_in = 1'b0;
    repeat (5) @(negedge clk);

    // Display multiplexing at 37.
    up_down = 1'b1;
    for (int i = 0; i < 37; i++) do_tick("to37");
    pulse(1'b0, 1'b1, 1'b0);
    a0 = an;
    for (int i = 0; i < 10 && an === a0; i++) @(negedge clk);
    chk("an_toggle", {12'b0, an}, {12'b0, a0 ^ 4'b0011});
    a0 = an;
    for (int k = 0; k < 16; k++) begin
      ea = (((k / 4) % 2) == 0) ? a0 : (a0 ^ 4'b0011);
      chk("an", {12'b0, an}, {12'b0, ea});
      chk("seg", {9'b0, seg}, {9'b0, (ea == 4'b1110) ? 7'b1111000 : 7'b0110000});
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
